// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared types and constants for the PC pipeline controller
package pc_ctrl_pkg;

   // Source of the next fetch PC
   typedef enum logic [2:0] {
      PC_SEQ,
      PC_BRANCH,
      PC_JALR,
      PC_TRAP,
      PC_MRET,
      PC_HOLD
   } pc_sel_e;

   // Fetch controller state: BOOT waits out IMEM latency after reset
   typedef enum logic {
      ST_BOOT,
      ST_RUN
   } ctrl_state_e;

   localparam int ILEN16_INC = 2;
   localparam int ILEN32_INC = 4;

endpackage

// File: rtl/pc_pipeline_controller_if.sv
// rtl/pc_pipeline_controller_if.sv - fetch/hazard/EX bundle for the PC controller (PC_TRAP_EN adds trap signals)
interface pc_pipeline_controller_if #(
   parameter int XLEN = 32
);

   logic            stallIFDE;
   logic            stallDEEX;
   logic            isCompressedIF;
   logic            branchTakenEX;
   logic            jumpEX;
   logic            jalrEX;
   logic [XLEN-1:0] immediateEX;
   logic [XLEN-1:0] jalrTargetEX;
   logic [XLEN-1:0] pcIF;
   logic [XLEN-1:0] pcDE;
   logic [XLEN-1:0] pcEX;
   logic [XLEN-1:0] pcLinkEX;
   logic            fetchValid;
   logic            flushIFDE;
   logic            flushDEEX;
`ifdef PC_TRAP_EN
   logic            trapEX;
   logic            mretEX;
   logic [XLEN-1:0] trapVector;
   logic [XLEN-1:0] mepc;

   modport master (
      input  stallIFDE, stallDEEX, isCompressedIF, branchTakenEX, jumpEX, jalrEX,
      input  immediateEX, jalrTargetEX, trapEX, mretEX, trapVector,
      output pcIF, pcDE, pcEX, pcLinkEX, fetchValid, flushIFDE, flushDEEX, mepc
   );

   modport slave (
      output stallIFDE, stallDEEX, isCompressedIF, branchTakenEX, jumpEX, jalrEX,
      output immediateEX, jalrTargetEX, trapEX, mretEX, trapVector,
      input  pcIF, pcDE, pcEX, pcLinkEX, fetchValid, flushIFDE, flushDEEX, mepc
   );
`else
   modport master (
      input  stallIFDE, stallDEEX, isCompressedIF, branchTakenEX, jumpEX, jalrEX,
      input  immediateEX, jalrTargetEX,
      output pcIF, pcDE, pcEX, pcLinkEX, fetchValid, flushIFDE, flushDEEX
   );

   modport slave (
      output stallIFDE, stallDEEX, isCompressedIF, branchTakenEX, jumpEX, jalrEX,
      output immediateEX, jalrTargetEX,
      input  pcIF, pcDE, pcEX, pcLinkEX, fetchValid, flushIFDE, flushDEEX
   );
`endif

endinterface

// File: rtl/pc_stage_reg.sv
// rtl/pc_stage_reg.sv - {pc, compressed, valid} pipeline register with enable and flush
module pc_stage_reg #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            arstn,
   input  logic            en,
   input  logic            flush,
   input  logic [XLEN-1:0] pcIn,
   input  logic            cIn,
   input  logic            validIn,
   output logic [XLEN-1:0] pcOut,
   output logic            cOut,
   output logic            validOut
);

   // Flush only kills the valid bit; pc/compressed keep their last value
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         pcOut    <= '0;
         cOut     <= 1'b0;
         validOut <= 1'b0;
      end else if (flush) begin
         validOut <= 1'b0;
      end else if (en) begin
         pcOut    <= pcIn;
         cOut     <= cIn;
         validOut <= validIn;
      end
   end

endmodule

// File: rtl/pc_pipeline_controller.sv
// rtl/pc_pipeline_controller.sv - PC register, next-PC select, DE/EX PC copies, flushes (optional PC_TRAP_EN)
module pc_pipeline_controller
   import pc_ctrl_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              BOOT_CYCLES  = 1
) (
   input logic                      clk,
   input logic                      arstn,
   pc_pipeline_controller_if.master bus
);

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

   ctrl_state_e     state;
   ctrl_state_e     stateNext;
   logic [3:0]      bootCnt;
   logic            running;

   logic            stallAny;
   logic            redirectReq;
   logic            killAll;
   pc_sel_e         pcSel;

   logic [XLEN-1:0] pcReg;
   logic [XLEN-1:0] pcNext;

   logic [XLEN-1:0] pcDEq;
   logic            cDE;
   logic            validDE;
   logic [XLEN-1:0] pcEXq;
   logic            cEX;
   logic            validEX;

`ifdef PC_TRAP_EN
   logic            trapTake;
   logic            mretTake;
   logic [XLEN-1:0] mepcReg;
`endif

   // State register plus boot counter, which only advances while booting
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state   <= ST_BOOT;
         bootCnt <= '0;
      end else begin
         state <= stateNext;
         if (state == ST_BOOT) begin
            bootCnt <= bootCnt + 4'd1;
         end
      end
   end

   // Leave BOOT once IMEM latency is covered; RUN is only left through reset
   always_comb begin
      stateNext = state;
      if (state == ST_BOOT && bootCnt == BOOT_LAST) begin
         stateNext = ST_RUN;
      end
   end

   // FSM outputs: fetch is requested only in RUN
   always_comb begin
      running = (state == ST_RUN);
   end

   assign stallAny    = bus.stallIFDE | bus.stallDEEX;
   assign redirectReq = running & validEX & ~bus.stallDEEX
                      & (bus.branchTakenEX | bus.jumpEX | bus.jalrEX);

`ifdef PC_TRAP_EN
   // A trap is taken even while DE/EX is stalled; MRET waits like a redirect
   assign trapTake = running & validEX & bus.trapEX;
   assign mretTake = running & validEX & ~bus.stallDEEX & bus.mretEX;
   assign killAll  = redirectReq | trapTake | mretTake;
`else
   assign killAll  = redirectReq;
`endif

   // Next-PC source in priority order; BOOT holds the reset vector
   always_comb begin
      pcSel = PC_SEQ;
      if (!running) begin
         pcSel = PC_HOLD;
`ifdef PC_TRAP_EN
      end else if (trapTake) begin
         pcSel = PC_TRAP;
      end else if (mretTake) begin
         pcSel = PC_MRET;
`endif
      end else if (redirectReq && bus.jalrEX) begin
         pcSel = PC_JALR;
      end else if (redirectReq) begin
         pcSel = PC_BRANCH;
      end else if (stallAny) begin
         pcSel = PC_HOLD;
      end
   end

   // Next-PC datapath; all additions wrap modulo 2^XLEN
   always_comb begin
      pcNext = pcReg;
      case (pcSel)
         PC_SEQ:    pcNext = pcReg + (bus.isCompressedIF ? XLEN'(ILEN16_INC) : XLEN'(ILEN32_INC));
         PC_BRANCH: pcNext = pcEXq + bus.immediateEX;
         PC_JALR:   pcNext = bus.jalrTargetEX & ~XLEN'(1);
`ifdef PC_TRAP_EN
         PC_TRAP:   pcNext = bus.trapVector & ~XLEN'(3);
         PC_MRET:   pcNext = mepcReg;
`endif
         default:   pcNext = pcReg;
      endcase
   end

   // Fetch PC register
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         pcReg <= RESET_VECTOR;
      end else begin
         pcReg <= pcNext;
      end
   end

`ifdef PC_TRAP_EN
   // Capture the trapping instruction's PC for the later MRET
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         mepcReg <= '0;
      end else if (trapTake) begin
         mepcReg <= pcEXq;
      end
   end

   assign bus.mepc = mepcReg;
`endif

   // A DE/EX stall also freezes IF/DE so nothing is overwritten in DE
   pc_stage_reg #(.XLEN(XLEN)) u_stageDE (
      .clk      (clk),
      .arstn    (arstn),
      .en       (~stallAny),
      .flush    (killAll),
      .pcIn     (pcReg),
      .cIn      (bus.isCompressedIF),
      .validIn  (running),
      .pcOut    (pcDEq),
      .cOut     (cDE),
      .validOut (validDE)
   );

   pc_stage_reg #(.XLEN(XLEN)) u_stageEX (
      .clk      (clk),
      .arstn    (arstn),
      .en       (~bus.stallDEEX),
      .flush    (killAll),
      .pcIn     (pcDEq),
      .cIn      (cDE),
      .validIn  (validDE),
      .pcOut    (pcEXq),
      .cOut     (cEX),
      .validOut (validEX)
   );

   assign bus.pcIF       = pcReg;
   assign bus.pcDE       = pcDEq;
   assign bus.pcEX       = pcEXq;
   assign bus.pcLinkEX   = pcEXq + (cEX ? XLEN'(ILEN16_INC) : XLEN'(ILEN32_INC));
   assign bus.fetchValid = running;
   assign bus.flushIFDE  = killAll;
   assign bus.flushDEEX  = killAll;

endmodule

// File: tb/tb_pc_pipeline_controller.sv
// tb/tb_pc_pipeline_controller.sv - self-checking bench for pc_pipeline_controller
module tb_pc_pipeline_controller;

   localparam int          BOOT_CYCLES  = 2;
   localparam logic [31:0] RESET_VECTOR = 32'h80;

   logic clk;
   logic arstn;
   int   tests = 0;
   int   fails = 0;

   pc_pipeline_controller_if #(.XLEN(32)) bus ();

   pc_pipeline_controller #(
      .XLEN         (32),
      .RESET_VECTOR (RESET_VECTOR),
      .BOOT_CYCLES  (BOOT_CYCLES)
   ) dut (
      .clk   (clk),
      .arstn (arstn),
      .bus   (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: pipeline held as plain records, advanced once per cycle
   int unsigned mCnt;
   logic [31:0] mPc, mDePc, mExPc, mMepc;
   logic        mDeC, mDeV, mExC, mExV;

   initial begin : model
      logic        run, redir, trapT, mretT, kill;
      logic [31:0] nPc;
      forever begin
         @(negedge clk);
         if (!arstn) begin
            mCnt = 0; mPc = RESET_VECTOR; mDePc = 0; mExPc = 0; mMepc = 0;
            mDeC = 0; mDeV = 0; mExC = 0; mExV = 0;
         end
         run   = (mCnt >= BOOT_CYCLES);
         redir = run && mExV && !bus.stallDEEX && (bus.branchTakenEX || bus.jumpEX || bus.jalrEX);
         trapT = 1'b0;
         mretT = 1'b0;
`ifdef PC_TRAP_EN
         trapT = run && mExV && bus.trapEX;
         mretT = run && mExV && !bus.stallDEEX && bus.mretEX;
         chk("m_mepc", bus.mepc, mMepc);
`endif
         kill = redir || trapT || mretT;
         if (run && mExV && bus.jalrEX && bus.jumpEX)
            $display("[TB] illegal decode: jalrEX and jumpEX together at pcEX=%h", mExPc);
         chk("m_pcIF", bus.pcIF, mPc);
         chk("m_pcDE", bus.pcDE, mDePc);
         chk("m_pcEX", bus.pcEX, mExPc);
         chk("m_fetchValid", 32'(bus.fetchValid), 32'(run));
         chk("m_flushIFDE", 32'(bus.flushIFDE), 32'(kill));
         chk("m_flushDEEX", 32'(bus.flushDEEX), 32'(kill));
         if (mExV) chk("m_pcLinkEX", bus.pcLinkEX, mExPc + (mExC ? 32'd2 : 32'd4));
         if (arstn) begin
            if (!run)                     nPc = mPc;
`ifdef PC_TRAP_EN
            else if (trapT)               nPc = {bus.trapVector[31:2], 2'b00};
            else if (mretT)               nPc = mMepc;
`endif
            else if (redir && bus.jalrEX) nPc = {bus.jalrTargetEX[31:1], 1'b0};
            else if (redir)               nPc = mExPc + bus.immediateEX;
            else if (bus.stallIFDE || bus.stallDEEX) nPc = mPc;
            else                          nPc = mPc + (bus.isCompressedIF ? 32'd2 : 32'd4);
            if (trapT) mMepc = mExPc;
            if (kill) mExV = 1'b0;
            else if (!bus.stallDEEX) begin mExPc = mDePc; mExC = mDeC; mExV = mDeV; end
            if (kill) mDeV = 1'b0;
            else if (!(bus.stallIFDE || bus.stallDEEX)) begin mDePc = mPc; mDeC = bus.isCompressedIF; mDeV = run; end
            mPc = nPc;
            if (mCnt < 1000) mCnt++;
         end
      end
   end

   // Directed stimulus with hand-computed literal expectations
   initial begin : stim
      bit found;
      arstn = 1'b0;
      bus.stallIFDE = 0; bus.stallDEEX = 0; bus.isCompressedIF = 0;
      bus.branchTakenEX = 0; bus.jumpEX = 0; bus.jalrEX = 0;
      bus.immediateEX = 0; bus.jalrTargetEX = 0;
`ifdef PC_TRAP_EN
      bus.trapEX = 0; bus.mretEX = 0; bus.trapVector = 0;
`endif
      repeat (2) tick();
      @(negedge clk);
      chk("rst_pcIF", bus.pcIF, 32'h80);
      chk("rst_fetchValid", 32'(bus.fetchValid), 0);
      chk("rst_pcDE", bus.pcDE, 0);
      chk("rst_pcEX", bus.pcEX, 0);
      chk("rst_flush", 32'(bus.flushIFDE), 0);

      // Boot: two cycles with fetchValid low, then 0x80, 0x84, 0x88
      tick(); arstn = 1'b1;
      @(negedge clk); chk("boot0_fetchValid", 32'(bus.fetchValid), 0);
      tick(); @(negedge clk); chk("boot1_fetchValid", 32'(bus.fetchValid), 0);
      chk("boot1_pcIF", bus.pcIF, 32'h80);
      tick(); @(negedge clk); chk("run0_fetchValid", 32'(bus.fetchValid), 1);
      chk("run0_pcIF", bus.pcIF, 32'h80);
      tick(); @(negedge clk); chk("run1_pcIF", bus.pcIF, 32'h84);
      tick(); @(negedge clk); chk("run2_pcIF", bus.pcIF, 32'h88);

      // Mixed RVC from 0x100
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (bus.pcIF == 32'h100) found = 1;
      end
      chk("reach_0x100", 32'(found), 1);
      bus.isCompressedIF = 1;
      tick(); bus.isCompressedIF = 0;
      @(negedge clk); chk("rvc_pcIF_102", bus.pcIF, 32'h102);
      tick(); bus.isCompressedIF = 1;
      @(negedge clk); chk("rvc_pcIF_106", bus.pcIF, 32'h106);
      chk("rvc_pcEX", bus.pcEX, 32'h100);
      chk("rvc_pcLinkEX", bus.pcLinkEX, 32'h102);
      tick(); bus.isCompressedIF = 0;
      @(negedge clk); chk("rvc_pcIF_108", bus.pcIF, 32'h108);

      // Taken branch at pcEX=0x200, imm=-8
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick();
         if (bus.pcEX == 32'h200) found = 1;
      end
      chk("reach_pcEX_200", 32'(found), 1);
      bus.branchTakenEX = 1; bus.immediateEX = 32'hFFFF_FFF8;
      @(negedge clk);
      chk("br_flushIFDE", 32'(bus.flushIFDE), 1);
      chk("br_flushDEEX", 32'(bus.flushDEEX), 1);
      tick(); @(negedge clk);
      chk("br_pcIF", bus.pcIF, 32'h1F8);
      chk("br_killedEX_noflush", 32'(bus.flushDEEX), 0);
      tick(); @(negedge clk);
      chk("br_killedDE_noflush", 32'(bus.flushDEEX), 0);
      tick(); bus.branchTakenEX = 0; bus.immediateEX = 0;

      // JALR beats stallIFDE
      bus.jalrEX = 1; bus.jalrTargetEX = 32'h1235; bus.stallIFDE = 1;
      @(negedge clk);
      chk("jalr_pcEX", bus.pcEX, 32'h1F8);
      chk("jalr_flushIFDE", 32'(bus.flushIFDE), 1);
      tick(); bus.jalrEX = 0; bus.stallIFDE = 0;
      @(negedge clk); chk("jalr_pcIF", bus.pcIF, 32'h1234);

      // JALR held behind three cycles of stallDEEX
      tick(); tick();
      bus.jalrEX = 1; bus.jalrTargetEX = 32'h1235; bus.stallDEEX = 1;
      for (int i = 0; i < 3; i++) begin
         if (i != 0) tick();
         @(negedge clk);
         chk("stl_noflush", 32'(bus.flushIFDE), 0);
         chk("stl_pcIF_hold", bus.pcIF, 32'h123C);
      end
      tick(); bus.stallDEEX = 0;
      @(negedge clk);
      chk("stl_release_flush", 32'(bus.flushDEEX), 1);
      chk("stl_release_pcEX", bus.pcEX, 32'h1234);
      tick(); bus.jalrEX = 0;
      @(negedge clk); chk("stl_pcIF", bus.pcIF, 32'h1234);

      // Wrap-around, 32-bit then 16-bit
      tick(); tick();
      bus.jalrEX = 1; bus.jalrTargetEX = 32'hFFFF_FFFC;
      tick(); bus.jalrEX = 0;
      @(negedge clk); chk("wrap_pcIF_fffc", bus.pcIF, 32'hFFFF_FFFC);
      tick(); @(negedge clk); chk("wrap32_pcIF", bus.pcIF, 32'h0);
      tick();
      bus.jalrEX = 1; bus.jalrTargetEX = 32'hFFFF_FFFF;
      @(negedge clk); chk("wrap_pcLinkEX", bus.pcLinkEX, 32'h0);
      tick(); bus.jalrEX = 0; bus.isCompressedIF = 1;
      @(negedge clk); chk("wrap_pcIF_fffe", bus.pcIF, 32'hFFFF_FFFE);
      tick(); bus.isCompressedIF = 0;
      @(negedge clk); chk("wrap16_pcIF", bus.pcIF, 32'h0);

      // JALR and JAL together: JALR wins
      tick();
      bus.jalrEX = 1; bus.jumpEX = 1; bus.jalrTargetEX = 32'h40; bus.immediateEX = 32'h1000;
      @(negedge clk); chk("dual_flush", 32'(bus.flushIFDE), 1);
      tick(); bus.jalrEX = 0; bus.jumpEX = 0; bus.immediateEX = 0;
      @(negedge clk); chk("dual_pcIF", bus.pcIF, 32'h40);

`ifdef PC_TRAP_EN
      // Trap at pcEX=0x40 (ignores stallDEEX), then MRET back
      tick(); tick();
      bus.trapEX = 1; bus.trapVector = 32'h303; bus.stallDEEX = 1;
      @(negedge clk);
      chk("trap_flushIFDE", 32'(bus.flushIFDE), 1);
      chk("trap_flushDEEX", 32'(bus.flushDEEX), 1);
      tick(); bus.trapEX = 0; bus.stallDEEX = 0;
      @(negedge clk);
      chk("trap_pcIF", bus.pcIF, 32'h300);
      chk("trap_mepc", bus.mepc, 32'h40);
      tick(); tick();
      bus.mretEX = 1;
      @(negedge clk);
      chk("mret_flushIFDE", 32'(bus.flushIFDE), 1);
      chk("mret_flushDEEX", 32'(bus.flushDEEX), 1);
      tick(); bus.mretEX = 0;
      @(negedge clk); chk("mret_pcIF", bus.pcIF, 32'h40);
`endif

      // Mid-operation reset returns everything at once and reboots
      tick(); tick();
      arstn = 1'b0;
      #1;
      chk("midrst_pcIF", bus.pcIF, 32'h80);
      chk("midrst_fetchValid", 32'(bus.fetchValid), 0);
      chk("midrst_pcEX", bus.pcEX, 0);
      tick(); arstn = 1'b1;
      @(negedge clk); chk("reboot0_fetchValid", 32'(bus.fetchValid), 0);
      tick(); @(negedge clk); chk("reboot1_fetchValid", 32'(bus.fetchValid), 0);
      tick(); @(negedge clk); chk("reboot2_fetchValid", 32'(bus.fetchValid), 1);
      tick(); @(negedge clk); chk("reboot_pcIF", bus.pcIF, 32'h84);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_pipeline_controller.md
Name: pc_pipeline_controller

Overview:
- Parametrised successor to the core's fetch controller: owns the PC register plus the PC/valid pipeline copies for DE and EX stages.
- Selects next PC: sequential +2/+4 (RVC-aware), branch/JAL, JALR.
- Generates IF/DE and DE/EX flushes and the EX-stage link address.
- Sits between the fetch unit, the hazard unit (stall inputs) and the EX-stage branch logic.

Parameters:
XLEN, 32, datapath/PC width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits)
BOOT_CYCLES, 1, cycles fetchValid stays low after reset release (1..15); covers synchronous IMEM latency

Ports:
clk  in  1  core clock
arstn  in  1  asynchronous active-low reset
stallIFDE  in  1  hold PC and IF/DE stage
stallDEEX  in  1  hold DE/EX stage; implies stallIFDE
isCompressedIF  in  1  instruction at pcIF is 16-bit
branchTakenEX  in  1  conditional branch in EX resolved taken
jumpEX  in  1  JAL in EX
jalrEX  in  1  JALR in EX
immediateEX  in  XLEN  sign-extended B/J immediate of EX instruction
jalrTargetEX  in  XLEN  rs1+imm from ALU
pcIF  out  XLEN  fetch PC
pcDE  out  XLEN  PC of DE instruction
pcEX  out  XLEN  PC of EX instruction
pcLinkEX  out  XLEN  return address of EX instruction
fetchValid  out  1  fetch request valid
flushIFDE  out  1  kill IF/DE register contents
flushDEEX  out  1  kill DE/EX register contents

Behaviour:
- Reset (async, arstn=0): pcIF=RESET_VECTOR; pcDE=pcEX=0; validDE=validEX=0; compressed flags 0; state=BOOT; bootCnt=0; fetchValid=0; flushes 0.
- FSM: BOOT -> RUN when bootCnt==BOOT_CYCLES-1. In BOOT, PC is held, all redirect inputs are ignored and flushes stay 0.
  - RUN: fetchValid=1. No return to BOOT except via reset.
- redirectReq = validEX & ~stallDEEX & (branchTakenEX | jumpEX | jalrEX).
- Next-PC priority, highest first:
  - trap (optional feature)
  - JALR -> {jalrTargetEX[XLEN-1:1],1'b0}
  - branch/JAL -> pcEX + immediateEX, modulo 2^XLEN
  - stall (stallIFDE|stallDEEX) -> hold
  - sequential -> pcIF + (isCompressedIF ? 2 : 4), modulo 2^XLEN (wraps 0xFFFF_FFFE+2 -> 0)
- A redirect overrides stallIFDE. It is suppressed while stallDEEX=1: EX holds its request, so it is taken in the first unstalled cycle.
- Flushes are combinational in the redirect cycle: flushIFDE = flushDEEX = redirectReq.
- Stage registers, updated on rising edge:
  - DE: if flushIFDE, validDE<=0. Else if ~stallIFDE, {pcDE,cDE,validDE} <= {pcIF,isCompressedIF,fetchValid}. Else hold.
  - EX: if flushDEEX, validEX<=0. Else if ~stallDEEX, take DE contents. Else hold.
  - If stallDEEX=1 while stallIFDE=0, treat as both stalled.
- pcLinkEX = pcEX + (cEX ? 2 : 4); combinational; valid whenever validEX=1.
- Redirect latency: target appears on pcIF one cycle after the redirect cycle. Instructions in IF/DE are discarded (2-cycle penalty).
- Simultaneous jalrEX and jumpEX: JALR wins; the bench flags it as illegal decode.
- Mid-operation reset: everything returns to reset values asynchronously; BOOT restarts.

Optional Feature:
- Macro PC_TRAP_EN.
- Defined: adds the following ports:
  - inputs trapEX (1), mretEX (1), trapVector (XLEN)
  - output mepc (XLEN); mepc resets to 0
- Trap behaviour: trapEX & validEX has top priority and ignores stallDEEX. Next PC = {trapVector[XLEN-1:2],2'b00}, mepc <= pcEX, both flushes asserted.
- MRET behaviour: mretEX & validEX & ~stallDEEX has second priority. Next PC = mepc, both flushes asserted.
- Undefined: ports absent, no mepc register; priority list starts at JALR.

Decomposition:
- Package pc_ctrl_pkg:
  - enum pc_sel_e {PC_SEQ, PC_BRANCH, PC_JALR, PC_TRAP, PC_MRET, PC_HOLD}
  - enum ctrl_state_e {ST_BOOT, ST_RUN}
  - localparams ILEN16_INC=2, ILEN32_INC=4
- Sub-module pc_stage_reg (XLEN-parametrised {pc, compressed, valid} register with enable and flush), instantiated twice for DE and EX.
- The PC register itself stays inline.

Test Plan:
- Reset, BOOT_CYCLES=2, RESET_VECTOR=0x80 -> fetchValid low 2 cycles, pcIF=0x80 held; then 0x84, 0x88.
- Mixed RVC: isCompressedIF sequence 1,0,1 from 0x100 -> pcIF 0x102, 0x106, 0x108. For the 16-bit EX instruction at 0x100, pcLinkEX=0x102.
- Branch taken with pcEX=0x200, immediateEX=-8 -> flushIFDE=flushDEEX=1 for one cycle; next pcIF=0x1F8; validDE=validEX=0 afterwards.
- JALR with jalrTargetEX=0x1235 and stallIFDE=1 in the same cycle -> redirect wins; pcIF=0x1234. Same request with stallDEEX=1 for 3 cycles -> no flush until stall drops, then redirect.
- Wrap: pcIF=0xFFFF_FFFC, 32-bit -> 0x0; with isCompressedIF at 0xFFFF_FFFE -> 0x0.
- PC_TRAP_EN: trapEX at pcEX=0x40, trapVector=0x303 -> pcIF=0x300, mepc=0x40. A later mretEX -> pcIF=0x40, both flushes pulse.
